// File: rtl/bank_register_param.sv
// ----------------------------------------------------------------------------
// bank_register_param
//
// Register bank of NUM_REGS x DATA_W general registers. Three of them have
// dedicated update channels:
//   PC_IDX : program counter, loaded from pc_data_in on pc_inc
//   SP_IDX : stack pointer, stepped by SP_STEP on push (down) / pop (up)
//   SR_IDX : status register, low FLAG_W bits merged from sr_flags on sr_en
// A general write to any of these three registers overrides its side channel
// in the same cycle.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-low reset
//   src_reg      in   index read onto a
//   dst_reg      in   index read onto b
//   a, b         out  registered read data (one-cycle latency, write-first)
//   wr_en        in   general write strobe
//   wr_reg       in   general write index (>= NUM_REGS is ignored)
//   wr_data      in   general write data
//   pc_inc       in   load pc_data_in into PC
//   pc_data_in   in   new PC value
//   pc_data_out  out  registered PC value
//   sp_push      in   SP <= SP - SP_STEP
//   sp_pop       in   SP <= SP + SP_STEP (push+pop together holds SP)
//   sp_data_out  out  registered SP value
//   sr_en        in   merge sr_flags into SR[FLAG_W-1:0]
//   sr_flags     in   flag values from the ALU
//   sr_data_out  out  registered SR value
//
// Every request completes at the edge it is presented; there is no stall.
// ----------------------------------------------------------------------------
module bank_register_param #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int PC_IDX   = 0,
    parameter int SP_IDX   = 1,
    parameter int SR_IDX   = 2,
    parameter int FLAG_W   = 4,
    parameter int SP_STEP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src_reg,
    input  logic [ADDR_W-1:0] dst_reg,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pc_inc,
    input  logic [DATA_W-1:0] pc_data_in,
    output logic [DATA_W-1:0] pc_data_out,
    input  logic              sp_push,
    input  logic              sp_pop,
    output logic [DATA_W-1:0] sp_data_out,
    input  logic              sr_en,
    input  logic [FLAG_W-1:0] sr_flags,
    output logic [DATA_W-1:0] sr_data_out
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] pc_q, sp_q, sr_q;

    logic wr_in_range;
    logic src_in_range;
    logic dst_in_range;

    assign wr_in_range  = (int'(wr_reg)  < NUM_REGS);
    assign src_in_range = (int'(src_reg) < NUM_REGS);
    assign dst_in_range = (int'(dst_reg) < NUM_REGS);

    // Next-state of the whole bank. Side channels are applied first and the
    // general write last, so a general write to PC/SP/SR wins by overriding.
    always_comb begin
        regs_d = regs_q;

        if (pc_inc) begin
            regs_d[PC_IDX] = pc_data_in;
        end

        // Push and pop together cancel; arithmetic wraps modulo 2^DATA_W.
        if (sp_push && !sp_pop) begin
            regs_d[SP_IDX] = regs_q[SP_IDX] - DATA_W'(SP_STEP);
        end else if (sp_pop && !sp_push) begin
            regs_d[SP_IDX] = regs_q[SP_IDX] + DATA_W'(SP_STEP);
        end

        if (sr_en) begin
            regs_d[SR_IDX][FLAG_W-1:0] = sr_flags;
        end

        if (wr_en && wr_in_range) begin
            regs_d[wr_reg] = wr_data;
        end
    end

    // Read ports sample the post-edge contents (write-first bypass).
    always_comb begin
        a_d = '0;
        b_d = '0;
        if (src_in_range) begin
            a_d = regs_d[src_reg];
        end
        if (dst_in_range) begin
            b_d = regs_d[dst_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            a_q  <= '0;
            b_q  <= '0;
            pc_q <= '0;
            sp_q <= '0;
            sr_q <= '0;
        end else begin
            regs_q <= regs_d;
            a_q    <= a_d;
            b_q    <= b_d;
            pc_q   <= regs_d[PC_IDX];
            sp_q   <= regs_d[SP_IDX];
            sr_q   <= regs_d[SR_IDX];
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign pc_data_out = pc_q;
    assign sp_data_out = sp_q;
    assign sr_data_out = sr_q;

endmodule
